// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - byte-stream to instruction-memory word writer
//
// Accepts bytes over a valid/ready handshake, packs them MSB-first into N-bit
// words and writes each word to consecutive addresses starting at 0. The core
// is stalled through busy while a load runs.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, num_words    begin a load of num_words words (sampled in IDLE)
//   abort               cancel the current load
//   byte_valid/data     incoming byte stream, byte_ready back-pressure
//   mem_we/addr/wdata   instruction-memory write port
//   busy, done, error   load in progress, completion pulse, rejected-start flag
//   checksum            XOR of all bytes accepted in the current load

module instr_mem_loader #(
    parameter int N     = 24,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW:0]   num_words,
    input  logic          abort,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [N-1:0]  mem_wdata,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [7:0]    checksum
);

    localparam int BPW = N / 8;
    localparam int BCW = $clog2(BPW + 1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);
    localparam logic [AW:0]    DEPTH_W   = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   word_q, word_d;
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [AW:0]    num_words_q, num_words_d;
    logic [7:0]     checksum_q, checksum_d;
    logic           error_q, error_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            word_q      <= '0;
            byte_cnt_q  <= '0;
            addr_q      <= '0;
            num_words_q <= '0;
            checksum_q  <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            byte_cnt_q  <= byte_cnt_d;
            addr_q      <= addr_d;
            num_words_q <= num_words_d;
            checksum_q  <= checksum_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        byte_cnt_d  = byte_cnt_q;
        addr_d      = addr_q;
        num_words_d = num_words_q;
        checksum_d  = checksum_q;
        error_d     = error_q;

        case (state_q)
            S_IDLE: begin
                // abort outranks start, so a coincident abort swallows the start
                if (start && !abort) begin
                    if (num_words == '0 || num_words > DEPTH_W) begin
                        error_d = 1'b1;
                    end else begin
                        num_words_d = num_words;
                        error_d     = 1'b0;
                        checksum_d  = '0;
                        byte_cnt_d  = '0;
                        addr_d      = '0;
                        word_d      = '0;
                        state_d     = S_RECV;
                    end
                end
            end
            S_RECV: begin
                // byte_ready is high throughout RECV, so byte_valid alone
                // completes the handshake, even on an abort cycle
                if (byte_valid) begin
                    word_d     = (word_q << 8) | N'(byte_data);
                    checksum_d = checksum_q ^ byte_data;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_d = S_WRITE;
                    end
                end
                if (abort) begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if ({1'b0, addr_q} == num_words_q - 1'b1) begin
                    state_d = S_DONE;
                end else begin
                    addr_d     = addr_q + 1'b1;
                    byte_cnt_d = '0;
                    state_d    = S_RECV;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign byte_ready = (state_q == S_RECV);
    // an abort landing on the WRITE cycle suppresses that write
    assign mem_we     = (state_q == S_WRITE) && !abort;
    assign mem_addr   = addr_q;
    assign mem_wdata  = word_q;
    assign busy       = (state_q == S_RECV) || (state_q == S_WRITE);
    assign done       = (state_q == S_DONE);
    assign error      = error_q;
    assign checksum   = checksum_q;

endmodule
